// File: rtl/mem_copy_engine_pkg.sv
// Shared encodings for the memory copy/fill engine: FSM states, mode values
// and the zero word that drives the idle bus.
package mem_copy_engine_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    localparam logic [31:0] WORD_ZERO = 32'd0;

endpackage

// File: rtl/mem_copy_engine.sv
// Block-transfer master for the data memory: copies a run of words forward
// (read/write alternating) or fills a region with a constant, one word per write.
module mem_copy_engine
    import mem_copy_engine_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    output logic              mem_read,
    output logic              mem_write
);

    state_e              state_q;
    logic [ADDR_W-1:0]   src_ptr_q;
    logic [ADDR_W-1:0]   dst_ptr_q;
    logic [CNT_W-1:0]    remaining_q;
    logic                mode_q;
    logic [DATA_W-1:0]   buf_q;

    // In fill mode buf_q holds the constant for the whole run; in copy mode it
    // is reloaded from memory at the end of every READ cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            remaining_q <= '0;
            mode_q      <= MODE_COPY;
            buf_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        src_ptr_q   <= src_addr;
                        dst_ptr_q   <= dst_addr;
                        remaining_q <= word_count;
                        mode_q      <= mode;
                        buf_q       <= fill_value;
                        if (word_count == '0) begin
                            state_q <= S_DONE;
                        end else if (mode == MODE_FILL) begin
                            state_q <= S_WRITE;
                        end else begin
                            state_q <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    buf_q   <= read_data;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    dst_ptr_q   <= dst_ptr_q + ADDR_W'(1);
                    remaining_q <= remaining_q - CNT_W'(1);
                    if (mode_q == MODE_COPY) begin
                        src_ptr_q <= src_ptr_q + ADDR_W'(1);
                    end
                    if (remaining_q == CNT_W'(1)) begin
                        state_q <= S_DONE;
                    end else if (mode_q == MODE_COPY) begin
                        state_q <= S_READ;
                    end else begin
                        state_q <= S_WRITE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs depend only on the state register so an async reset clears them at once.
    always_comb begin
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        mem_read   = (state_q == S_READ);
        mem_write  = (state_q == S_WRITE);
        address    = ADDR_W'(WORD_ZERO);
        write_data = DATA_W'(WORD_ZERO);
        if (state_q == S_READ) begin
            address = src_ptr_q;
        end else if (state_q == S_WRITE) begin
            address    = dst_ptr_q;
            write_data = buf_q;
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench: drives mem_copy_engine against a 64 Ki-word memory and
// scores every read/write against a queue built from a shadow memory model.
module tb_mem_copy_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mode;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] word_count;
    logic [31:0] fill_value;
    logic        busy;
    logic        done;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        mem_read;
    logic        mem_write;

    logic [31:0] mem    [0:65535];
    logic [31:0] shadow [0:65535];
    logic        tbWrEn;
    logic [15:0] tbWrAddr;
    logic [31:0] tbWrData;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         writeQ [$];
    logic [31:0] readQ  [$];

    int errCount;
    int checkCount;

    mem_copy_engine #(
        .ADDR_W(32),
        .DATA_W(32),
        .CNT_W (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .word_count(word_count),
        .fill_value(fill_value),
        .busy      (busy),
        .done      (done),
        .address   (address),
        .write_data(write_data),
        .read_data (read_data),
        .mem_read  (mem_read),
        .mem_write (mem_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The memory decodes only the low 16 address bits; the read bus idles low here.
    assign read_data = mem_read ? mem[address[15:0]] : 32'd0;

    always @(posedge clk) begin
        if (mem_write) begin
            mem[address[15:0]] <= write_data;
        end else if (tbWrEn) begin
            mem[tbWrAddr] <= tbWrData;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] v);
        @(negedge clk);
        tbWrEn   = 1'b1;
        tbWrAddr = a;
        tbWrData = v;
        shadow[a] = v;
        @(negedge clk);
        tbWrEn = 1'b0;
    endtask

    task automatic applyStimulus(input logic m, input logic [31:0] s, input logic [31:0] d,
                                 input logic [15:0] n, input logic [31:0] fv,
                                 input int expDone, input int extraStartCycle,
                                 input int resetCycle);
        int          doneCycle;
        int          doneCount;
        int          conflicts;
        int          idleLeak;
        int          reads;
        int          writes;
        logic [31:0] pre [0:15];
        logic [31:0] sa;
        logic [31:0] da;
        logic [31:0] val;
        wr_t         e;
        doneCycle = 0;
        doneCount = 0;
        conflicts = 0;
        idleLeak  = 0;
        reads     = 0;
        writes    = 0;
        writeQ.delete();
        readQ.delete();
        // Forward copy on the shadow so overlapping regions produce the repeated pattern.
        for (int k = 0; k < int'(n); k++) begin
            sa = s + 32'(k);
            da = d + 32'(k);
            if (k < 16) pre[k] = shadow[da[15:0]];
            val = m ? fv : shadow[sa[15:0]];
            if (!m) readQ.push_back(sa);
            shadow[da[15:0]] = val;
            writeQ.push_back('{da, val});
        end
        @(negedge clk);
        start      = 1'b1;
        mode       = m;
        src_addr   = s;
        dst_addr   = d;
        word_count = n;
        fill_value = fv;
        for (int c = 1; c <= expDone + 3; c++) begin
            @(negedge clk);
            start = (c == extraStartCycle);
            if (c == extraStartCycle) begin
                mode       = 1'b1;
                dst_addr   = 32'd200;
                word_count = 16'd5;
            end
            if (mem_read && mem_write) conflicts++;
            if (!mem_read && !mem_write && (address != 0 || write_data != 0)) idleLeak++;
            if (mem_read) begin
                reads++;
                if (readQ.size() == 0) checkOutput("unexpRead", 1, 0);
                else checkOutput("readAddr", address, readQ.pop_front());
            end
            if (mem_write) begin
                writes++;
                if (writeQ.size() == 0) begin
                    checkOutput("unexpWrite", 1, 0);
                end else begin
                    e = writeQ.pop_front();
                    checkOutput("writeAddr", address, e.addr);
                    checkOutput("writeData", write_data, e.data);
                end
            end
            if (done) begin
                doneCount++;
                if (doneCycle == 0) begin
                    doneCycle = c;
                    checkOutput("busyAtDone", busy, 1);
                end
            end
            if (doneCycle != 0 && c == doneCycle + 1) checkOutput("idleBusy", busy, 0);
            if (c == resetCycle) begin
                rst = 1'b1;
                #1;
                checkOutput("rstCtrl", {busy, done, mem_read, mem_write}, 0);
                checkOutput("rstAddr", address, 0);
                checkOutput("rstWdata", write_data, 0);
                @(negedge clk);
                rst = 1'b0;
                break;
            end
        end
        start = 1'b0;
        if (resetCycle == 0) begin
            checkOutput("doneCycle", doneCycle, expDone);
            checkOutput("doneCount", doneCount, 1);
            checkOutput("rdWrConflict", conflicts, 0);
            checkOutput("idleBusLeak", idleLeak, 0);
            checkOutput("readCount", reads, m ? 0 : int'(n));
            checkOutput("writeCount", writes, int'(n));
            checkOutput("writeQLeft", writeQ.size(), 0);
            checkOutput("readQLeft", readQ.size(), 0);
            for (int k = 0; k <= int'(n); k++) begin
                da = d + 32'(k);
                checkOutput("memWord", mem[da[15:0]], shadow[da[15:0]]);
            end
        end else begin
            // Abort: word 0 is committed, word 1 may or may not be, the rest are untouched.
            checkOutput("rstNoDone", doneCount, 0);
            checkOutput("rstWord0", mem[d[15:0]], shadow[d[15:0]]);
            da = d + 32'd1;
            checkOutput("rstWord1", (mem[da[15:0]] == pre[1]) || (mem[da[15:0]] == shadow[da[15:0]]), 1);
            shadow[da[15:0]] = mem[da[15:0]];
            for (int k = 2; k < int'(n); k++) begin
                da = d + 32'(k);
                checkOutput("rstWordKeep", mem[da[15:0]], pre[k]);
                shadow[da[15:0]] = pre[k];
            end
            writeQ.delete();
            readQ.delete();
        end
    endtask

    initial begin
        errCount   = 0;
        checkCount = 0;
        rst        = 1'b1;
        start      = 1'b0;
        mode       = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        word_count = '0;
        fill_value = '0;
        tbWrEn     = 1'b0;
        tbWrAddr   = '0;
        tbWrData   = '0;
        for (int i = 0; i < 65536; i++) shadow[i] = 32'd0;
        #1;
        checkOutput("resetCtrl", {busy, done, mem_read, mem_write}, 0);
        checkOutput("resetAddr", address, 0);
        checkOutput("resetWdata", write_data, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("[TB] copy 4 words");
        for (int k = 0; k < 4; k++) preload(16'(16 + k), 32'(k + 1));
        for (int k = 0; k < 5; k++) preload(16'(64 + k), 32'hA5A5_0000 + 32'(k));
        applyStimulus(1'b0, 32'd16, 32'd64, 16'd4, 32'd0, 9, 0, 0);

        $display("[TB] fill 3 words");
        for (int k = 0; k < 4; k++) preload(16'(100 + k), 32'h1111_0000 + 32'(k));
        applyStimulus(1'b1, 32'd0, 32'd100, 16'd3, 32'hDEAD_BEEF, 4, 0, 0);

        $display("[TB] zero count");
        preload(16'd300, 32'h3300_0000);
        applyStimulus(1'b0, 32'd16, 32'd300, 16'd0, 32'd0, 1, 0, 0);

        $display("[TB] fill across 64Ki wrap");
        preload(16'hFFFF, 32'h5555_0000);
        preload(16'h0000, 32'h5555_0001);
        preload(16'h0001, 32'h5555_0002);
        applyStimulus(1'b1, 32'd0, 32'h0000_FFFF, 16'd2, 32'd7, 3, 0, 0);

        $display("[TB] overlapping copy with ignored start");
        preload(16'd10, 32'd5);
        for (int k = 0; k < 4; k++) preload(16'(11 + k), 32'hC0 + 32'(k));
        for (int k = 0; k < 6; k++) preload(16'(200 + k), 32'h2000 + 32'(k));
        applyStimulus(1'b0, 32'd10, 32'd11, 16'd3, 32'd0, 7, 3, 0);
        for (int k = 0; k < 6; k++) checkOutput("ignoredStart", mem[200 + k], 32'h2000 + 32'(k));

        $display("[TB] reset mid-copy");
        for (int k = 0; k < 8; k++) preload(16'(400 + k), 32'h100 + 32'(k));
        for (int k = 0; k < 8; k++) preload(16'(500 + k), 32'hEE + 32'(k));
        applyStimulus(1'b0, 32'd400, 32'd500, 16'd8, 32'd0, 17, 0, 4);

        $display("[TB] copy after reset");
        for (int k = 0; k < 3; k++) preload(16'(600 + k), 32'h6000 + 32'(k));
        applyStimulus(1'b0, 32'd403, 32'd600, 16'd2, 32'd0, 5, 0, 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Block-transfer initiator for the single-port word-addressed data memory. On a `start` pulse it copies a run of words from a source region to a destination region, or fills the destination with a constant, by sequencing `mem_read` and `mem_write` cycles on the memory's port. It sits beside the datapath as the master of the data memory interface, time-multiplexed with the processor's load/store path by a top-level select outside this block.

## Interface
Parameters:
- `ADDR_W`, 32: memory address width.
- `DATA_W`, 32: word width.
- `CNT_W`, 16: width of the word-count field.

Ports:
- `clk`  in  1: single clock; all state changes on posedge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request; sampled only in IDLE.
- `mode`  in  1: 0 = copy, 1 = fill.
- `src_addr`  in  ADDR_W: first source word address (ignored in fill).
- `dst_addr`  in  ADDR_W: first destination word address.
- `word_count`  in  CNT_W: number of words; 0 is legal.
- `fill_value`  in  DATA_W: word written in fill mode.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse on completion.
- `address`  out  ADDR_W: memory address.
- `write_data`  out  DATA_W: memory write data.
- `read_data`  in  DATA_W: memory read data; combinational from memory, high-Z when `mem_read` is low.
- `mem_read`  out  1: memory read enable.
- `mem_write`  out  1: memory write enable; the memory writes on posedge.

## Operation
- States: IDLE, READ, WRITE, DONE. Moore outputs decoded from state and registers.
- IDLE: all outputs 0. On `start`=1, latch `src_addr`, `dst_addr`, `word_count`, `mode` and `fill_value` into `src_ptr`, `dst_ptr`, `remaining`, `mode_r` and `buf`.
  - `word_count`=0 goes to DONE.
  - Otherwise copy mode goes to READ and fill mode goes to WRITE.
- READ: `mem_read`=1, `address`=`src_ptr`. At the edge, `buf` <= `read_data`, then go to WRITE.
- WRITE: `mem_write`=1, `address`=`dst_ptr`, `write_data`=`buf`.
  - At the edge, `dst_ptr`+1 and `remaining`-1. `src_ptr`+1 in copy mode only.
  - If `remaining`==1, go to DONE.
  - Else copy mode goes to READ and fill mode stays in WRITE.
- DONE: `done`=1 and `busy`=1, then IDLE next cycle.
- `mem_read` and `mem_write` are never high together. `address` and `write_data` are 0 whenever the block is neither reading nor writing.
- `start` while not in IDLE is ignored. Nothing is queued.
- Pointers increment modulo 2^ADDR_W, so 32'hFFFF_FFFF wraps to 0. The memory decodes only the low 16 bits, so regions wrap at 64 Ki words.
- The copy is strictly forward, ascending. With overlap and `dst_addr` > `src_addr`, the destination holds the repeated pattern that a forward copy produces. This is defined behaviour, not an error.

## Timing
- Reset: state=IDLE; `busy`, `done`, `mem_read`, `mem_write`, `address` and `write_data` are all 0 immediately, without waiting for a clock edge. Reset mid-transfer aborts. Words already written stay written; no further access occurs.
- Copy of N≥1 words: 2N+1 cycles from the cycle after the `start` edge until `done` deasserts. READ/WRITE alternate; word k is written in cycle 2k+2 counted from the start edge (k from 0).
- Fill of N≥1 words: N+1 cycles. Back-to-back WRITE cycles, one word per cycle.
- N=0: the cycle after the start edge is DONE. There is no memory access.
- The `read_data` sample is taken at the end of the READ cycle, once combinational memory data has settled.
- `start` is accepted again in the cycle after DONE, i.e. the first IDLE cycle.

## Structure
- Shared package or header: the state encoding constants (`S_IDLE`, `S_READ`, `S_WRITE`, `S_DONE`, 2 bits), `MODE_COPY`/`MODE_FILL`, and `WORD_ZERO`.
- Single module with no sub-module. The FSM, the pointer/counter registers and the output decode are all in one module; the counter is too small to justify splitting it out.
- The bench instantiates this block driving the existing data memory directly.

## Test plan
- Copy 4 words: preload mem[16..19]=1,2,3,4; start with src=16, dst=64, count=4 -> mem[64..67]=1,2,3,4. `done` is high exactly in cycle 9 after the start edge. mem_read and mem_write are never high together.
- Fill 3 words: dst=100, fill_value=32'hDEAD_BEEF -> mem[100..102]=DEADBEEF. `done` is in cycle 4. `mem_read` never asserts.
- Zero count: count=0, copy mode -> `done` in cycle 1. No `mem_read` or `mem_write` pulse. Memory is unchanged.
- Wrap: fill with dst=16'hFFFF, count=2, value=7 -> writes land at address[15:0]=FFFF and 0000.
- Overlap plus ignored start: copy with src=10, dst=11, count=3 and mem[10]=5 -> mem[11..13]=5. A second `start` pulsed while busy causes no extra transfer.
- Reset mid-copy: assert `rst` during the 2nd WRITE of an 8-word copy -> all outputs go to 0 before the next edge. Only the first 1 or 2 destination words have changed. A new start after reset completes normally.
